// File: rtl/proc_pkg.sv
// Shared constants, fetch FSM state type and opcode helper for the
// program-counter / instruction-fetch pair.
package proc_pkg;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 7;
    localparam int OPC_W  = 4;

    localparam logic [OPC_W-1:0] HALT_OP = 4'hF;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        WAIT  = 3'd2,
        HOLD  = 3'd3,
        HALT  = 3'd4
    } fetch_state_t;

    // The opcode lives in the top OPC_W bits of an instruction word.
    function automatic logic [OPC_W-1:0] opcode(input logic [DATA_W-1:0] word);
        return word[DATA_W-1 -: OPC_W];
    endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Instruction-register handshake between the fetch unit (master) and
// the decoder/controller (slave).
interface instr_fetch_if;
    import proc_pkg::*;

    logic [DATA_W-1:0] IR;
    logic [ADDR_W-1:0] IrAddr;
    logic              IrValid;
    logic              IrReady;

    modport master (
        output IR,
        output IrAddr,
        output IrValid,
        input  IrReady
    );

    modport slave (
        input  IR,
        input  IrAddr,
        input  IrValid,
        output IrReady
    );

endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch: reads the ROM at the PC address, latches the word into
// IR, offers it over valid/ready and advances the PC once per instruction.
module instr_fetch
    import proc_pkg::*;
(
    input  logic              Clk,
    input  logic              Clr,
    input  logic              Go,
    input  logic [ADDR_W-1:0] Addr,
    output logic              Up,
    output logic              RomRd,
    input  logic [DATA_W-1:0] RomData,
    output logic              Halted,
    instr_fetch_if.master     ir_bus
);

    fetch_state_t      r_state;
    fetch_state_t      w_state_next;

    logic [ADDR_W-1:0] r_fetch_addr;
    logic [DATA_W-1:0] r_ir;
    logic [ADDR_W-1:0] r_ir_addr;
    logic              r_ir_valid;
    logic              r_halted;

    logic              w_handshake;
    logic              w_rom_is_halt;
    logic              w_ir_is_halt;

    assign w_handshake   = (r_state == HOLD) && r_ir_valid && ir_bus.IrReady;
    assign w_rom_is_halt = (opcode(RomData) == HALT_OP);
    assign w_ir_is_halt  = (opcode(r_ir) == HALT_OP);

    // State register and datapath registers; Clr wins over any in-flight word.
    always_ff @(posedge Clk) begin
        if (Clr) begin
            r_state      <= IDLE;
            r_fetch_addr <= '0;
            r_ir         <= '0;
            r_ir_addr    <= '0;
            r_ir_valid   <= 1'b0;
            r_halted     <= 1'b0;
        end else begin
            r_state <= w_state_next;

            if (r_state == FETCH) begin
                r_fetch_addr <= Addr;
            end

            if (r_state == WAIT) begin
                r_ir       <= RomData;
                r_ir_addr  <= r_fetch_addr;
                r_ir_valid <= 1'b1;
            end

            if (w_handshake) begin
                r_ir_valid <= 1'b0;
                if (w_ir_is_halt) begin
                    r_halted <= 1'b1;
                end
            end
        end
    end

    // Next-state and strobes. Up is raised during WAIT, so the PC moves at the
    // end of WAIT and the new address is already visible while IR waits in HOLD.
    always_comb begin
        w_state_next = r_state;
        Up           = 1'b0;
        RomRd        = 1'b0;

        case (r_state)
            IDLE: begin
                if (Go) begin
                    w_state_next = FETCH;
                end
            end
            FETCH: begin
                RomRd        = 1'b1;
                w_state_next = WAIT;
            end
            WAIT: begin
                Up           = !w_rom_is_halt;
                w_state_next = HOLD;
            end
            HOLD: begin
                if (w_handshake) begin
                    w_state_next = w_ir_is_halt ? HALT : FETCH;
                end
            end
            HALT: begin
                w_state_next = HALT;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    assign ir_bus.IR      = r_ir;
    assign ir_bus.IrAddr  = r_ir_addr;
    assign ir_bus.IrValid = r_ir_valid;
    assign Halted         = r_halted;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench: behavioural PC + registered-read ROM around instr_fetch, checked
// against an instruction-stream model derived from the ROM contents.
module tb_instr_fetch;
    import proc_pkg::*;

    logic              clk = 1'b0;
    logic              clr;
    logic              go;
    logic [ADDR_W-1:0] addr;
    logic              up;
    logic              rom_rd;
    logic [DATA_W-1:0] rom_data;
    logic              halted;
    logic [DATA_W-1:0] rom [128];

    int n_checks   = 0;
    int n_errors   = 0;
    int up_total   = 0;
    int consec_err = 0;
    int cyc        = 0;
    logic prev_up  = 1'b0;

    instr_fetch_if bus();

    instr_fetch dut (
        .Clk     (clk),
        .Clr     (clr),
        .Go      (go),
        .Addr    (addr),
        .Up      (up),
        .RomRd   (rom_rd),
        .RomData (rom_data),
        .Halted  (halted),
        .ir_bus  (bus)
    );

    always #5 clk = ~clk;

    // Program counter: cleared with the fetch unit, wraps naturally at 127.
    always @(posedge clk) begin
        if (clr)     addr <= '0;
        else if (up) addr <= addr + 1'b1;
    end

    always @(posedge clk) begin
        if (rom_rd) rom_data <= rom[addr];
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (up && !clr) up_total <= up_total + 1;
        if (up && prev_up) consec_err <= consec_err + 1;
        prev_up <= up;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        clr         = 1'b1;
        go          = 1'b0;
        bus.IrReady = 1'b0;
        repeat (2) @(negedge clk);
        clr = 1'b0;
    endtask

    // Wait for an offered instruction, compare it, optionally stall, then accept it.
    task automatic fetch_one(input int stall, input logic [DATA_W-1:0] exp_ir,
                             input logic [ADDR_W-1:0] exp_addr, output int hs_cyc);
        int n = 0;
        logic [ADDR_W-1:0] exp_pc;
        exp_pc = (opcode(exp_ir) == HALT_OP) ? exp_addr : exp_addr + 1'b1;
        while (bus.IrValid !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check_val("valid_seen", 32'(bus.IrValid === 1'b1), 32'd1);
        check_val("ir", 32'(bus.IR), 32'(exp_ir));
        check_val("ir_addr", 32'(bus.IrAddr), 32'(exp_addr));
        check_val("pc_in_hold", 32'(addr), 32'(exp_pc));
        if (stall > 0) begin
            bus.IrReady = 1'b0;
            for (int k = 0; k < stall; k++) begin
                @(negedge clk);
                check_val("stall_ir", 32'(bus.IR), 32'(exp_ir));
                check_val("stall_valid", 32'(bus.IrValid), 32'd1);
                check_val("stall_up_rd", 32'({up, rom_rd}), 32'd0);
                check_val("stall_pc", 32'(addr), 32'(exp_pc));
            end
        end
        hs_cyc      = cyc;
        bus.IrReady = 1'b1;
        @(negedge clk);
        $display("xfer addr=%0d ir=%04h stall=%0d", exp_addr, exp_ir, stall);
    endtask

    // Model: instructions run sequentially from 0 (mod 128) until a HALT opcode;
    // each non-HALT instruction costs exactly one PC increment.
    task automatic run_program(input int max_instr, input int max_stall, input bit check_rate);
        logic [ADDR_W-1:0] a;
        int  base, exp_up, hs, prev_hs;
        bit  done;
        a = '0; base = up_total; exp_up = 0; prev_hs = -1; done = 1'b0;
        for (int i = 0; i < max_instr && !done; i++) begin
            fetch_one(int'($urandom_range(max_stall, 0)), rom[a], a, hs);
            if (check_rate && prev_hs >= 0) check_val("rate", 32'(hs - prev_hs), 32'd3);
            prev_hs = hs;
            if (opcode(rom[a]) == HALT_OP) begin
                done = 1'b1;
                check_val("halted", 32'(halted), 32'd1);
                check_val("halt_pc", 32'(addr), 32'(a));
            end else begin
                exp_up++;
                a = a + 1'b1;
                check_val("not_halted", 32'(halted), 32'd0);
            end
        end
        check_val("up_count", 32'(up_total - base), 32'(exp_up));
    endtask

    task automatic load_basic();
        for (int i = 0; i < 128; i++) rom[i] = '0;
        rom[0] = 16'h1001;
        rom[1] = 16'h2002;
        rom[2] = 16'h3003;
        rom[3] = 16'hF000;
    endtask

    initial begin
        int hs;

        // Idle after reset with Go low.
        load_basic();
        do_reset();
        check_val("rst_valid", 32'(bus.IrValid), 32'd0);
        check_val("rst_ir", 32'(bus.IR), 32'd0);
        check_val("rst_iraddr", 32'(bus.IrAddr), 32'd0);
        check_val("rst_halted", 32'(halted), 32'd0);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            check_val("idle_up_rd", 32'({up, rom_rd}), 32'd0);
            check_val("idle_pc", 32'(addr), 32'd0);
        end

        // Straight run to HALT at full rate.
        bus.IrReady = 1'b1;
        go = 1'b1;
        run_program(10, 0, 1'b1);

        // Go pulses in HALT are ignored.
        go = 1'b0;
        @(negedge clk);
        go = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check_val("halt_rd", 32'(rom_rd), 32'd0);
            check_val("halt_pc_hold", 32'(addr), 32'd3);
            check_val("halt_flag", 32'(halted), 32'd1);
        end

        // Clr then Go resumes at 0; first instruction stalled for 10 cycles.
        do_reset();
        go = 1'b1;
        fetch_one(10, 16'h1001, 7'd0, hs);
        fetch_one(0, 16'h2002, 7'd1, hs);

        // Clr during WAIT of the third fetch.
        do_reset();
        go = 1'b1;
        bus.IrReady = 1'b1;
        run_program(2, 0, 1'b0);
        check_val("fetch3_rd", 32'(rom_rd), 32'd1);
        @(negedge clk);
        check_val("wait3_up", 32'(up), 32'd1);
        clr = 1'b1;
        go  = 1'b0;
        @(negedge clk);
        clr = 1'b0;
        check_val("clr_valid", 32'(bus.IrValid), 32'd0);
        check_val("clr_ir", 32'(bus.IR), 32'd0);
        check_val("clr_pc", 32'(addr), 32'd0);
        check_val("clr_up_rd", 32'({up, rom_rd}), 32'd0);
        go = 1'b1;
        run_program(2, 1, 1'b0);

        // No HALT anywhere: 130 instructions wrap the address through 127 -> 0.
        for (int i = 0; i < 128; i++) rom[i] = '0;
        do_reset();
        go = 1'b1;
        run_program(130, 0, 1'b1);

        // Random programs with a HALT at a random spot and random stalls.
        for (int r = 0; r < 6; r++) begin
            int h;
            for (int i = 0; i < 128; i++)
                rom[i] = {4'($urandom_range(14, 0)), 12'($urandom)};
            h = int'($urandom_range(40, 1));
            rom[h] = {HALT_OP, 12'($urandom)};
            do_reset();
            go = 1'b1;
            run_program(200, 3, 1'b0);
        end

        check_val("no_back_to_back_up", 32'(consec_err), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
